// File: rtl/canvas_cell_scheduler_if.sv
// Handshake, VGA write-port and occupancy-map bundle shared by the canvas
// cell scheduler and whoever drives paint/clear requests.
interface canvas_cell_scheduler_if #(
  parameter int COLS = 14,
  parameter int ROWS = 14
);
  logic                   paint_req;
  logic [3:0]             paint_col;
  logic [3:0]             paint_row;
  logic                   paint_erase;
  logic                   paint_ack;
  logic                   clear_req;
  logic                   busy;
  logic                   done;
  logic [8:0]             vga_x;
  logic [8:0]             vga_y;
  logic [14:0]            vga_color;
  logic                   vga_plot;
  logic [ROWS*COLS-1:0]   cell_map;

  modport master (
    output paint_req, paint_col, paint_row, paint_erase, clear_req,
    input  paint_ack, busy, done, vga_x, vga_y, vga_color, vga_plot, cell_map
  );

  modport slave (
    input  paint_req, paint_col, paint_row, paint_erase, clear_req,
    output paint_ack, busy, done, vga_x, vga_y, vga_color, vga_plot, cell_map
  );
endinterface

// File: rtl/canvas_cell_scheduler.sv
// Arbitrates cell paint/erase and canvas clear requests, rasterises them one
// pixel per clock onto the VGA write port and keeps the cell occupancy map.
module canvas_cell_scheduler #(
  parameter logic [8:0]  X0     = 9'd88,
  parameter logic [8:0]  Y0     = 9'd37,
  parameter int          CELL_W = 10,
  parameter int          CELL_H = 14,
  parameter int          COLS   = 14,
  parameter int          ROWS   = 14,
  parameter logic [14:0] FG     = 15'h7FFF,
  parameter logic [14:0] BG     = 15'h0000
) (
  input logic clock,
  input logic reset,
  canvas_cell_scheduler_if.slave bus
);
  localparam int N_CELLS = ROWS * COLS;
  localparam int PX_W    = $clog2(COLS * CELL_W);
  localparam int PY_W    = $clog2(ROWS * CELL_H);
  localparam int IDX_W   = $clog2(N_CELLS);

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

  state_t             state, state_n;
  logic [PX_W-1:0]    px, px_n;
  logic [PY_W-1:0]    py, py_n;
  logic [3:0]         col, col_n, row, row_n;
  logic               erase, erase_n;
  logic               clear_pending, clear_pending_n;
  logic               ack, ack_n, done, done_n, plot, plot_n;
  logic [8:0]         vga_x, vga_x_n, vga_y, vga_y_n;
  logic [14:0]        color, color_n;
  logic [N_CELLS-1:0] cell_map, cell_map_n;

  logic               req_in_range, req_changes;
  logic [IDX_W-1:0]   req_idx, cur_idx;
  logic [PX_W-1:0]    px_last;
  logic [PY_W-1:0]    py_last;
  logic [8:0]         base_x, base_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      px            <= '0;
      py            <= '0;
      col           <= '0;
      row           <= '0;
      erase         <= 1'b0;
      clear_pending <= 1'b0;
      ack           <= 1'b0;
      done          <= 1'b0;
      plot          <= 1'b0;
      vga_x         <= '0;
      vga_y         <= '0;
      color         <= '0;
      cell_map      <= '0;
    end else begin
      state         <= state_n;
      px            <= px_n;
      py            <= py_n;
      col           <= col_n;
      row           <= row_n;
      erase         <= erase_n;
      clear_pending <= clear_pending_n;
      ack           <= ack_n;
      done          <= done_n;
      plot          <= plot_n;
      vga_x         <= vga_x_n;
      vga_y         <= vga_y_n;
      color         <= color_n;
      cell_map      <= cell_map_n;
    end
  end

  always_comb begin
    state_n         = state;
    px_n            = px;
    py_n            = py;
    col_n           = col;
    row_n           = row;
    erase_n         = erase;
    clear_pending_n = clear_pending | bus.clear_req;
    ack_n           = 1'b0;
    done_n          = 1'b0;
    plot_n          = 1'b0;
    vga_x_n         = vga_x;
    vga_y_n         = vga_y;
    color_n         = color;
    cell_map_n      = cell_map;

    req_idx      = IDX_W'(int'(bus.paint_row) * COLS + int'(bus.paint_col));
    req_in_range = (int'(bus.paint_col) < COLS) && (int'(bus.paint_row) < ROWS);
    // A request only needs drawing when the stored bit differs from the target (~erase).
    req_changes  = req_in_range && (cell_map[req_idx] == bus.paint_erase);
    cur_idx      = IDX_W'(int'(row) * COLS + int'(col));

    if (state == PAINT) begin
      px_last = PX_W'(CELL_W - 1);
      py_last = PY_W'(CELL_H - 1);
      base_x  = 9'(int'(X0) + int'(col) * CELL_W);
      base_y  = 9'(int'(Y0) + int'(row) * CELL_H);
    end else begin
      px_last = PX_W'(COLS * CELL_W - 1);
      py_last = PY_W'(ROWS * CELL_H - 1);
      base_x  = X0;
      base_y  = Y0;
    end

    case (state)
      IDLE: begin
        if (clear_pending || bus.clear_req) begin
          state_n         = CLEAR;
          clear_pending_n = 1'b0;
          px_n            = '0;
          py_n            = '0;
          plot_n          = 1'b1;
          vga_x_n         = X0;
          vga_y_n         = Y0;
          color_n         = BG;
        end else if (bus.paint_req) begin
          ack_n   = 1'b1;
          col_n   = bus.paint_col;
          row_n   = bus.paint_row;
          erase_n = bus.paint_erase;
          if (req_changes) begin
            state_n = PAINT;
            px_n    = '0;
            py_n    = '0;
            plot_n  = 1'b1;
            vga_x_n = 9'(int'(X0) + int'(bus.paint_col) * CELL_W);
            vga_y_n = 9'(int'(Y0) + int'(bus.paint_row) * CELL_H);
            color_n = bus.paint_erase ? BG : FG;
          end
        end
      end
      PAINT, CLEAR: begin
        if (px == px_last && py == py_last) begin
          px_n    = '0;
          py_n    = '0;
          done_n  = 1'b1;
          state_n = IDLE;
          if (state == PAINT) cell_map_n[cur_idx] = ~erase;
          else                cell_map_n = '0;
        end else begin
          if (px == px_last) begin
            px_n = '0;
            py_n = py + PY_W'(1);
          end else begin
            px_n = px + PX_W'(1);
          end
          plot_n  = 1'b1;
          vga_x_n = 9'(base_x + 9'(px_n));
          vga_y_n = 9'(base_y + 9'(py_n));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.paint_ack = ack;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.vga_x     = vga_x;
  assign bus.vga_y     = vga_y;
  assign bus.vga_color = color;
  assign bus.vga_plot  = plot;
  assign bus.cell_map  = cell_map;
endmodule

// File: doc/canvas_cell_scheduler.md
# canvas_cell_scheduler

Sequences all pixel writes into the VGA frame buffer for the handwriting canvas. It arbitrates between single-cell paint/erase requests from the mouse path and whole-canvas clear requests, then rasterises each accepted operation as one pixel per clock on the `vga_adapter` write port. It also keeps a registered one-bit-per-cell occupancy map, which is the input image for the neural-network core. It sits between the mouse/cell-quantisation logic and `vga_adapter`, and replaces ad-hoc draw/erase sequencing.

## Interface
Parameters:
- `X0`, 9'd88: screen x of canvas left edge.
- `Y0`, 9'd37: screen y of canvas top edge.
- `CELL_W`, 10: pixels per cell horizontally.
- `CELL_H`, 14: pixels per cell vertically.
- `COLS`, 14: cells per row.
- `ROWS`, 14: cells per column.
- `FG`, 15'h7FFF: painted-cell colour.
- `BG`, 15'h0000: empty-cell colour.

Ports:
- `clock`, in, 1: single clock (CLOCK_50 domain).
- `reset`, in, 1: synchronous, active-high.
- `paint_req`, in, 1: request to set or clear one cell; held until `paint_ack`.
- `paint_col`, in, 4: cell column.
- `paint_row`, in, 4: cell row.
- `paint_erase`, in, 1: 1 = make the cell empty, 0 = make it painted.
- `paint_ack`, out, 1: one-cycle pulse; the request was accepted.
- `clear_req`, in, 1: request a whole-canvas clear. Sampled each cycle; a pulse is enough.
- `busy`, out, 1: high while an operation is rasterising.
- `done`, out, 1: one-cycle pulse when an operation finishes.
- `vga_x`, out, 9: pixel x.
- `vga_y`, out, 9: pixel y.
- `vga_color`, out, 15: pixel colour.
- `vga_plot`, out, 1: write enable to `vga_adapter`.
- `cell_map`, out, ROWS*COLS: occupancy map; bit index is row*COLS+col; 1 = painted.

## Operation
- Reset values: all outputs are 0; `clear_pending` = 0; state = IDLE; `cell_map` = 0.
- FSM states: IDLE, PAINT, CLEAR.
- `clear_pending` register:
  - Set by `clear_req` in any state.
  - Cleared when a CLEAR operation starts.
- IDLE priority:
  - 1st: `clear_pending` or `clear_req` → go to CLEAR.
  - 2nd: `paint_req` → pulse `paint_ack` and latch `paint_col`, `paint_row` and `paint_erase`.
- After latching a paint request:
  - If col ≥ COLS or row ≥ ROWS: ack only. No plot, no `done`, stay in IDLE.
  - If `cell_map` already equals the target value: ack only, no plot, no `done`.
  - Otherwise go to PAINT.
- PAINT:
  - Rasterises CELL_W×CELL_H pixels in row-major order: x is the inner loop, y the outer.
  - vga_x = X0 + col*CELL_W + px and vga_y = Y0 + row*CELL_H + py (9-bit results).
  - Colour is BG if erasing, otherwise FG.
- CLEAR:
  - Rasterises (COLS*CELL_W)×(ROWS*CELL_H) pixels from (X0,Y0), row-major, in BG.
- Pixel counters px/py are sized with $clog2 of the canvas extent and wrap to 0 after the last pixel.
- `vga_plot` is high on every rasterised cycle and low otherwise. `vga_x`, `vga_y` and `vga_color` hold their last values when `vga_plot` is low.
- Commit on the last pixel edge:
  - PAINT: `cell_map[row*COLS+col]` becomes ~erase.
  - CLEAR: `cell_map` becomes all 0.
  - Then pulse `done` and return to IDLE.
- Requests during busy:
  - `paint_req` is not acknowledged; the requester keeps holding it.
  - `clear_req` sets `clear_pending` and is serviced immediately after the current operation, ahead of any paint.
- Reset mid-operation: the operation is aborted, `cell_map` is zeroed, and any pending clear is dropped. Pixels already drawn stay in the frame buffer.

## Timing
- `paint_req` sampled in IDLE at edge N:
  - `paint_ack`, `busy` and the first `vga_plot` are high in cycle N+1.
  - The last plot is in cycle N+CELL_W*CELL_H (N+140 with defaults).
  - `done` is high and the `cell_map` update is visible in cycle N+141; `busy` is low.
  - The earliest next acceptance is edge N+141.
- CLEAR with defaults: 140×196 = 27440 plot cycles, then `done`.
- Ack-only paint: `paint_ack` in N+1 with `busy` low. A new request can be accepted at edge N+1. The requester must drop `paint_req` the cycle after it sees the ack, otherwise the request is re-accepted.
- `clear_req` and `paint_req` in the same IDLE cycle: clear wins. The paint is not acked and is accepted after the clear's `done`.

## Test plan
- Reset, then paint col 0, row 0 → `paint_ack` in 1 cycle; 140 plots with x 88..97 and y 37..50 in FG; `done` after the last plot; `cell_map[0]` = 1.
- Paint col 13, row 13, then erase the same cell → pixels x 218..227, y 219..232; first pass in FG, second in BG; `cell_map[195]` goes 1 then 0.
- Paint an already-painted cell, and separately paint col 14 → each gets `paint_ack` with no `vga_plot`, no `done`, and `cell_map` unchanged.
- Pulse `clear_req` at pixel 50 of a paint → the paint completes; the clear starts without any IDLE paint acceptance; 27440 BG plots; `cell_map` = 0.
- Raise `clear_req` and `paint_req` in the same cycle → clear first; the paint is acked only after the clear's `done`.
- Assert `reset` during a CLEAR → next cycle all outputs are 0, FSM is in IDLE, no pending clear, and a fresh paint is accepted normally.
